// File: rtl/milano_csr_file.sv
// Machine-mode CSR file for the milano core: execute-stage read/write port,
// trusted trap-controller write port, 64-bit mcycle/minstret counters and
// registered timer/software interrupt pending bits.
module milano_csr_file #(
    parameter logic [31:0] MHARTID     = 32'h0,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        ex_csr_req_i,
    input  logic [11:0] ex_csr_raddr_i,
    output logic [31:0] ex_csr_rdata_o,
    input  logic        ex_csr_we_i,
    input  logic [11:0] ex_csr_waddr_i,
    input  logic [31:0] ex_csr_wdata_i,
    output logic        illegal_csr_o,
    input  logic        ctrl_csr_we_i,
    input  logic [11:0] ctrl_csr_waddr_i,
    input  logic [31:0] ctrl_csr_wdata_i,
    input  logic        timer_irq_i,
    input  logic        sw_irq_i,
    input  logic        instr_retire_i,
    output logic [31:0] csr_mstatus_o,
    output logic [31:0] csr_mepc_o,
    output logic [31:0] csr_mtvec_o,
    output logic [31:0] csr_mie_o,
    output logic [31:0] csr_mip_o
);

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;
    localparam logic [11:0] CSR_MIMPID    = 12'hF13;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam logic [31:0] MISA_VAL = 32'h4000_1100;
    localparam logic [31:0] MIE_MASK = 32'h0000_0888;

    function automatic logic csr_impl(input logic [11:0] a);
        case (a)
            CSR_MSTATUS, CSR_MISA, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC,
            CSR_MCAUSE, CSR_MTVAL, CSR_MIP, CSR_MCYCLE, CSR_MINSTRET, CSR_MCYCLEH,
            CSR_MINSTRETH, CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID, CSR_MHARTID:
                csr_impl = 1'b1;
            default: csr_impl = 1'b0;
        endcase
    endfunction

    logic        mstatus_mie_q, mstatus_mie_d;
    logic        mstatus_mpie_q, mstatus_mpie_d;
    logic [31:0] mie_q, mie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mtval_q, mtval_d;
    logic [1:0]  mip_q, mip_d;           // {MTIP, MSIP}
    logic [63:0] mcycle_q, mcycle_d;
    logic [63:0] minstret_q, minstret_d;

    logic [31:0] mstatus_rd, mip_rd;
    logic        cyc_wr, ins_wr;
    logic [1:0]        wr_en;
    logic [1:0][11:0]  wr_addr;
    logic [1:0][31:0]  wr_data;

    assign mstatus_rd = {19'b0, 2'b11, 3'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
    assign mip_rd     = {24'b0, mip_q[1], 3'b0, mip_q[0], 3'b0};

    assign csr_mstatus_o = mstatus_rd;
    assign csr_mepc_o    = mepc_q;
    assign csr_mtvec_o   = mtvec_q;
    assign csr_mie_o     = mie_q;
    assign csr_mip_o     = mip_rd;

    // Illegal access: bad read address, or a write to a read-only/unknown CSR
    always_comb begin
        illegal_csr_o = ex_csr_req_i & (~csr_impl(ex_csr_raddr_i) |
                        (ex_csr_we_i & ((ex_csr_waddr_i[11:10] == 2'b11) |
                                        ~csr_impl(ex_csr_waddr_i))));
    end

    // Read mux; shows pre-write state (no forwarding)
    always_comb begin
        case (ex_csr_raddr_i)
            CSR_MSTATUS:   ex_csr_rdata_o = mstatus_rd;
            CSR_MISA:      ex_csr_rdata_o = MISA_VAL;
            CSR_MIE:       ex_csr_rdata_o = mie_q;
            CSR_MTVEC:     ex_csr_rdata_o = mtvec_q;
            CSR_MSCRATCH:  ex_csr_rdata_o = mscratch_q;
            CSR_MEPC:      ex_csr_rdata_o = mepc_q;
            CSR_MCAUSE:    ex_csr_rdata_o = mcause_q;
            CSR_MTVAL:     ex_csr_rdata_o = mtval_q;
            CSR_MIP:       ex_csr_rdata_o = mip_rd;
            CSR_MCYCLE:    ex_csr_rdata_o = mcycle_q[31:0];
            CSR_MCYCLEH:   ex_csr_rdata_o = mcycle_q[63:32];
            CSR_MINSTRET:  ex_csr_rdata_o = minstret_q[31:0];
            CSR_MINSTRETH: ex_csr_rdata_o = minstret_q[63:32];
            CSR_MHARTID:   ex_csr_rdata_o = MHARTID;
            default:       ex_csr_rdata_o = 32'h0;
        endcase
    end

    // Port 1 (trap controller) is applied after port 0 so it wins on a collision
    assign wr_en   = {ctrl_csr_we_i, ex_csr_req_i & ex_csr_we_i & ~illegal_csr_o};
    assign wr_addr = {ctrl_csr_waddr_i, ex_csr_waddr_i};
    assign wr_data = {ctrl_csr_wdata_i, ex_csr_wdata_i};

    // Next-state: counter increments, interrupt sampling, then port writes
    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_d          = mie_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mtval_d        = mtval_q;
        mip_d          = {timer_irq_i, sw_irq_i};
        mcycle_d       = mcycle_q + 64'd1;
        minstret_d     = minstret_q + {63'd0, instr_retire_i};
        cyc_wr         = 1'b0;
        ins_wr         = 1'b0;
        for (int p = 0; p < 2; p++) begin
            if (wr_en[p]) begin
                case (wr_addr[p])
                    CSR_MSTATUS: begin
                        mstatus_mie_d  = wr_data[p][3];
                        mstatus_mpie_d = wr_data[p][7];
                    end
                    CSR_MIE:      mie_d      = wr_data[p] & MIE_MASK;
                    CSR_MTVEC:    mtvec_d    = {wr_data[p][31:2], 2'b00};
                    CSR_MSCRATCH: mscratch_d = wr_data[p];
                    CSR_MEPC:     mepc_d     = {wr_data[p][31:2], 2'b00};
                    CSR_MCAUSE:   mcause_d   = wr_data[p];
                    CSR_MTVAL:    mtval_d    = wr_data[p];
                    // Any write to a counter half freezes the whole counter this cycle
                    CSR_MCYCLE: begin
                        if (!cyc_wr) mcycle_d = mcycle_q;
                        mcycle_d[31:0] = wr_data[p];
                        cyc_wr = 1'b1;
                    end
                    CSR_MCYCLEH: begin
                        if (!cyc_wr) mcycle_d = mcycle_q;
                        mcycle_d[63:32] = wr_data[p];
                        cyc_wr = 1'b1;
                    end
                    CSR_MINSTRET: begin
                        if (!ins_wr) minstret_d = minstret_q;
                        minstret_d[31:0] = wr_data[p];
                        ins_wr = 1'b1;
                    end
                    CSR_MINSTRETH: begin
                        if (!ins_wr) minstret_d = minstret_q;
                        minstret_d[63:32] = wr_data[p];
                        ins_wr = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= 32'h0;
            mtvec_q        <= MTVEC_RESET & ~32'h3;
            mscratch_q     <= 32'h0;
            mepc_q         <= 32'h0;
            mcause_q       <= 32'h0;
            mtval_q        <= 32'h0;
            mip_q          <= 2'b00;
            mcycle_q       <= 64'h0;
            minstret_q     <= 64'h0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_q          <= mie_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
            mip_q          <= mip_d;
            mcycle_q       <= mcycle_d;
            minstret_q     <= minstret_d;
        end
    end

endmodule

// File: tb/tb_milano_csr_file.sv
// Randomized bench for milano_csr_file: a register-level reference model,
// a compare process checking every output each cycle, and literal pins.
module tb_milano_csr_file;

    localparam logic [31:0] HART  = 32'h5;
    localparam logic [31:0] TVECR = 32'h8000_0003;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        ex_csr_req_i = 1'b0;
    logic [11:0] ex_csr_raddr_i = 12'h0;
    logic [31:0] ex_csr_rdata_o;
    logic        ex_csr_we_i = 1'b0;
    logic [11:0] ex_csr_waddr_i = 12'h0;
    logic [31:0] ex_csr_wdata_i = 32'h0;
    logic        illegal_csr_o;
    logic        ctrl_csr_we_i = 1'b0;
    logic [11:0] ctrl_csr_waddr_i = 12'h0;
    logic [31:0] ctrl_csr_wdata_i = 32'h0;
    logic        timer_irq_i = 1'b0;
    logic        sw_irq_i = 1'b0;
    logic        instr_retire_i = 1'b0;
    logic [31:0] csr_mstatus_o, csr_mepc_o, csr_mtvec_o, csr_mie_o, csr_mip_o;

    milano_csr_file #(.MHARTID(HART), .MTVEC_RESET(TVECR)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .ex_csr_req_i(ex_csr_req_i), .ex_csr_raddr_i(ex_csr_raddr_i),
        .ex_csr_rdata_o(ex_csr_rdata_o), .ex_csr_we_i(ex_csr_we_i),
        .ex_csr_waddr_i(ex_csr_waddr_i), .ex_csr_wdata_i(ex_csr_wdata_i),
        .illegal_csr_o(illegal_csr_o), .ctrl_csr_we_i(ctrl_csr_we_i),
        .ctrl_csr_waddr_i(ctrl_csr_waddr_i), .ctrl_csr_wdata_i(ctrl_csr_wdata_i),
        .timer_irq_i(timer_irq_i), .sw_irq_i(sw_irq_i), .instr_retire_i(instr_retire_i),
        .csr_mstatus_o(csr_mstatus_o), .csr_mepc_o(csr_mepc_o), .csr_mtvec_o(csr_mtvec_o),
        .csr_mie_o(csr_mie_o), .csr_mip_o(csr_mip_o)
    );

    always #5 clk_i = ~clk_i;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] mstatus, mie, mtvec, mscratch, mepc, mcause, mtval, mip;
        logic [63:0] cyc, ins;
    } mstate_t;

    localparam logic [11:0] IMPL [17] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340,
        12'h341, 12'h342, 12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82,
        12'hF11, 12'hF12, 12'hF13, 12'hF14};

    mstate_t m;

    function automatic logic is_impl(input logic [11:0] a);
        foreach (IMPL[i]) if (IMPL[i] == a) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic m_ill();
        if (!ex_csr_req_i) return 1'b0;
        if (!is_impl(ex_csr_raddr_i)) return 1'b1;
        return ex_csr_we_i && (ex_csr_waddr_i >= 12'hC00 || !is_impl(ex_csr_waddr_i));
    endfunction

    function automatic mstate_t m_reset();
        mstate_t s;
        s = '0;
        s.mstatus = 32'h0000_1800;
        s.mtvec   = TVECR & 32'hFFFF_FFFC;
        return s;
    endfunction

    function automatic logic [31:0] m_rd(input mstate_t s, input logic [11:0] a);
        case (a)
            12'h300: return s.mstatus;
            12'h301: return 32'h4000_1100;
            12'h304: return s.mie;
            12'h305: return s.mtvec;
            12'h340: return s.mscratch;
            12'h341: return s.mepc;
            12'h342: return s.mcause;
            12'h343: return s.mtval;
            12'h344: return s.mip;
            12'hB00: return s.cyc[31:0];
            12'hB80: return s.cyc[63:32];
            12'hB02: return s.ins[31:0];
            12'hB82: return s.ins[63:32];
            12'hF14: return HART;
            default: return 32'h0;
        endcase
    endfunction

    function automatic mstate_t m_wr(input mstate_t s, input logic [11:0] a, input logic [31:0] d);
        mstate_t n;
        n = s;
        case (a)
            12'h300: n.mstatus = 32'h0000_1800 | (d & 32'h88);
            12'h304: n.mie = d & 32'h888;
            12'h305: n.mtvec = d & 32'hFFFF_FFFC;
            12'h340: n.mscratch = d;
            12'h341: n.mepc = d & 32'hFFFF_FFFC;
            12'h342: n.mcause = d;
            12'h343: n.mtval = d;
            12'hB00: n.cyc[31:0] = d;
            12'hB80: n.cyc[63:32] = d;
            12'hB02: n.ins[31:0] = d;
            12'hB82: n.ins[63:32] = d;
            default: ;
        endcase
        return n;
    endfunction

    function automatic mstate_t m_step(input mstate_t s);
        mstate_t n;
        logic exw, cw, iw;
        exw = ex_csr_req_i && ex_csr_we_i && !m_ill();
        cw = (exw && (ex_csr_waddr_i == 12'hB00 || ex_csr_waddr_i == 12'hB80)) ||
             (ctrl_csr_we_i && (ctrl_csr_waddr_i == 12'hB00 || ctrl_csr_waddr_i == 12'hB80));
        iw = (exw && (ex_csr_waddr_i == 12'hB02 || ex_csr_waddr_i == 12'hB82)) ||
             (ctrl_csr_we_i && (ctrl_csr_waddr_i == 12'hB02 || ctrl_csr_waddr_i == 12'hB82));
        n = s;
        n.cyc = cw ? s.cyc : s.cyc + 64'd1;
        n.ins = (iw || !instr_retire_i) ? s.ins : s.ins + 64'd1;
        n.mip = (timer_irq_i ? 32'h80 : 32'h0) | (sw_irq_i ? 32'h8 : 32'h0);
        if (exw) n = m_wr(n, ex_csr_waddr_i, ex_csr_wdata_i);
        if (ctrl_csr_we_i) n = m_wr(n, ctrl_csr_waddr_i, ctrl_csr_wdata_i);
        return n;
    endfunction

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) m <= m_reset();
        else m <= m_step(m);
    end

    // ---------------- compare process ----------------
    int    checks = 0;
    int    failures = 0;
    logic  lit_on = 1'b0;
    string lit_name = "";
    logic [31:0] lit_rd = '0;
    logic  lit_ill = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got=%h expected=%h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        chk("rdata",   ex_csr_rdata_o, m_rd(m, ex_csr_raddr_i));
        chk("illegal", {31'b0, illegal_csr_o}, {31'b0, m_ill()});
        chk("mstatus", csr_mstatus_o, m.mstatus);
        chk("mepc",    csr_mepc_o, m.mepc);
        chk("mtvec",   csr_mtvec_o, m.mtvec);
        chk("mie",     csr_mie_o, m.mie);
        chk("mip",     csr_mip_o, m.mip);
        if (lit_on) begin
            chk({"pin_rd_", lit_name}, ex_csr_rdata_o, lit_rd);
            chk({"pin_ill_", lit_name}, {31'b0, illegal_csr_o}, {31'b0, lit_ill});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk_i);
        #1;
        lit_on = 1'b0;
        ex_csr_req_i = 1'b0; ex_csr_we_i = 1'b0; ctrl_csr_we_i = 1'b0;
        instr_retire_i = 1'b0;
    endtask

    task automatic ex(input logic we, input logic [11:0] ra, input logic [11:0] wa,
                      input logic [31:0] wd);
        ex_csr_req_i = 1'b1; ex_csr_we_i = we;
        ex_csr_raddr_i = ra; ex_csr_waddr_i = wa; ex_csr_wdata_i = wd;
    endtask

    task automatic ctrl(input logic [11:0] wa, input logic [31:0] wd);
        ctrl_csr_we_i = 1'b1; ctrl_csr_waddr_i = wa; ctrl_csr_wdata_i = wd;
    endtask

    task automatic pin(input string nm, input logic [31:0] rd, input logic ill);
        lit_on = 1'b1; lit_name = nm; lit_rd = rd; lit_ill = ill;
    endtask

    localparam logic [11:0] POOL [21] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340,
        12'h341, 12'h342, 12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82,
        12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'h7C0, 12'h123, 12'hC00, 12'hF15};

    initial begin
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;

        // Reset values
        ex(1'b0, 12'h300, 12'h0, 32'h0); pin("mstatus_rst", 32'h0000_1800, 1'b0); tick();
        ex(1'b0, 12'h301, 12'h0, 32'h0); pin("misa", 32'h4000_1100, 1'b0); tick();
        ex(1'b0, 12'hF14, 12'h0, 32'h0); pin("mhartid", 32'h5, 1'b0); tick();
        ex(1'b0, 12'h305, 12'h0, 32'h0); pin("mtvec_rst", 32'h8000_0000, 1'b0); tick();

        // Write masks; each read shows the previous cycle's write
        ex(1'b1, 12'h300, 12'h300, 32'hFFFF_FFFF); pin("mstatus_prewr", 32'h0000_1800, 1'b0); tick();
        ex(1'b1, 12'h300, 12'h304, 32'hFFFF_FFFF); pin("mstatus_wr", 32'h0000_1888, 1'b0); tick();
        ex(1'b1, 12'h304, 12'h305, 32'hFFFF_FFFF); pin("mie_wr", 32'h0000_0888, 1'b0); tick();
        ex(1'b1, 12'h305, 12'h341, 32'hFFFF_FFFF); pin("mtvec_wr", 32'hFFFF_FFFC, 1'b0); tick();
        ex(1'b0, 12'h341, 12'h0, 32'h0); pin("mepc_wr", 32'hFFFF_FFFC, 1'b0); tick();

        // Port collision
        ex(1'b1, 12'h342, 12'h342, 32'h1); ctrl(12'h342, 32'h8000_0007); tick();
        ex(1'b0, 12'h342, 12'h0, 32'h0); pin("mcause_ctrl_wins", 32'h8000_0007, 1'b0); tick();
        ex(1'b1, 12'h342, 12'h342, 32'h1); ctrl(12'h341, 32'h0000_1235); tick();
        ex(1'b0, 12'h342, 12'h0, 32'h0); pin("mcause_both", 32'h1, 1'b0); tick();
        ex(1'b0, 12'h341, 12'h0, 32'h0); pin("mepc_both", 32'h0000_1234, 1'b0); tick();

        // mcycle carry
        ex(1'b1, 12'hB00, 12'hB00, 32'hFFFF_FFFE); tick();
        ex(1'b1, 12'hB00, 12'hB80, 32'h0); pin("mcycle_held", 32'hFFFF_FFFE, 1'b0); tick();
        ex(1'b0, 12'hB00, 12'h0, 32'h0); pin("mcycle_fe", 32'hFFFF_FFFE, 1'b0); tick();
        ex(1'b0, 12'hB00, 12'h0, 32'h0); pin("mcycle_ff", 32'hFFFF_FFFF, 1'b0); tick();
        ex(1'b0, 12'hB00, 12'h0, 32'h0); pin("mcycle_wrap", 32'h0, 1'b0); tick();
        ex(1'b0, 12'hB80, 12'h0, 32'h0); pin("mcycleh_carry", 32'h1, 1'b0); tick();

        // minstret
        tick(); tick();
        ex(1'b0, 12'hB02, 12'h0, 32'h0); pin("minstret_idle", 32'h0, 1'b0); tick();
        for (int i = 0; i < 3; i++) begin
            instr_retire_i = 1'b1; tick(); tick();
        end
        ex(1'b0, 12'hB02, 12'h0, 32'h0); pin("minstret_3", 32'h3, 1'b0); tick();

        // Illegal access and read-only writes
        ex(1'b1, 12'h7C0, 12'hF14, 32'hDEAD_BEEF); pin("illegal", 32'h0, 1'b1); tick();
        ex(1'b0, 12'hF14, 12'h0, 32'h0); pin("mhartid_kept", 32'h5, 1'b0); tick();
        ctrl(12'h301, 32'h0); tick();
        ex(1'b0, 12'h301, 12'h0, 32'h0); pin("misa_kept", 32'h4000_1100, 1'b0); tick();

        // Timer interrupt level sampling
        timer_irq_i = 1'b1; ex(1'b0, 12'h344, 12'h0, 32'h0); pin("mip_n", 32'h0, 1'b0); tick();
        ex(1'b0, 12'h344, 12'h0, 32'h0); pin("mip_n1", 32'h80, 1'b0); tick();
        timer_irq_i = 1'b0; ex(1'b0, 12'h344, 12'h0, 32'h0); pin("mip_m", 32'h80, 1'b0); tick();
        ex(1'b0, 12'h344, 12'h0, 32'h0); pin("mip_m1", 32'h0, 1'b0); tick();

        // Randomized traffic checked against the model every cycle
        for (int c = 0; c < 3000; c++) begin
            ex_csr_req_i     = ($urandom_range(0, 3) != 0);
            ex_csr_we_i      = $urandom_range(0, 1);
            ex_csr_raddr_i   = POOL[$urandom_range(0, 20)];
            ex_csr_waddr_i   = POOL[$urandom_range(0, 20)];
            ex_csr_wdata_i   = $urandom;
            ctrl_csr_we_i    = ($urandom_range(0, 3) == 0);
            ctrl_csr_waddr_i = ($urandom_range(0, 3) == 0) ? ex_csr_waddr_i
                                                           : POOL[$urandom_range(0, 20)];
            ctrl_csr_wdata_i = $urandom;
            timer_irq_i      = $urandom_range(0, 1);
            sw_irq_i         = $urandom_range(0, 1);
            instr_retire_i   = $urandom_range(0, 1);
            @(posedge clk_i);
            #1;
        end
        tick();

        // Asynchronous reset mid-count
        tick(); tick();
        ex(1'b0, 12'hB00, 12'h0, 32'h0);
        rst_ni = 1'b0;
        pin("mcycle_async_rst", 32'h0, 1'b0);
        @(negedge clk_i);
        #1 rst_ni = 1'b1;
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/milano_csr_file.md
# milano_csr_file

Machine-mode CSR register file for the milano core. It sits downstream of the trap controller and of the execute stage. It accepts CSR writes from both, serves CSR reads to the execute stage, and keeps the 64-bit mcycle/minstret counters. It also samples the timer and software interrupt lines into mip and feeds mstatus/mepc/mtvec/mie/mip back to the trap controller.

## Interface
- MHARTID, 32'h0, value returned by mhartid (0xF14)
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec; bits [1:0] ignored
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- ex_csr_req_i  in  1  execute stage issues a CSR instruction this cycle
- ex_csr_raddr_i  in  12  execute-stage read address
- ex_csr_rdata_o  out  32  read data, combinational
- ex_csr_we_i  in  1  execute-stage write enable, qualified by ex_csr_req_i
- ex_csr_waddr_i  in  12  execute-stage write address
- ex_csr_wdata_i  in  32  execute-stage write data
- illegal_csr_o  out  1  illegal CSR access flag, combinational
- ctrl_csr_we_i  in  1  trap-controller write enable
- ctrl_csr_waddr_i  in  12  trap-controller write address
- ctrl_csr_wdata_i  in  32  trap-controller write data
- timer_irq_i  in  1  machine timer interrupt level
- sw_irq_i  in  1  machine software interrupt level
- instr_retire_i  in  1  one instruction retired this cycle
- csr_mstatus_o, csr_mepc_o, csr_mtvec_o, csr_mie_o, csr_mip_o  out  32 each  current register values

## Operation
- Implemented CSRs and their write masks:
  - mstatus 0x300: only MIE[3] and MPIE[7] are writable; MPP[12:11] reads 2'b11; all other bits read 0.
  - misa 0x301: read-only, 32'h4000_1100.
  - mie 0x304: only bits 3, 7 and 11 are writable.
  - mtvec 0x305: bits [31:2] writable; [1:0] read 0 (direct mode only).
  - mscratch 0x340, mcause 0x342, mtval 0x343: full 32 bits writable.
  - mepc 0x341: [1:0] forced to 0.
  - mip 0x344: read-only. MTIP[7] = sampled timer_irq_i, MSIP[3] = sampled sw_irq_i; other bits 0.
  - mcycle/mcycleh 0xB00/0xB80 and minstret/minstreth 0xB02/0xB82: read/write.
  - mvendorid 0xF11, marchid 0xF12, mimpid 0xF13: read 0. mhartid 0xF14 reads MHARTID.
- A read of an unimplemented address returns 32'h0.
- illegal_csr_o = ex_csr_req_i & (raddr not implemented | (ex_csr_we_i & (waddr[11:10]==2'b11 | waddr not implemented))).
  - When illegal_csr_o is set, the execute-stage write is dropped.
- Trap-controller writes are trusted and are not checked. Writes to read-only or unimplemented addresses from this port are ignored silently.
- Both ports write the same register in the same cycle: the trap-controller value wins. Different registers: both writes take effect.
- mcycle increments by 1 every cycle. minstret increments by 1 when instr_retire_i=1. The carry from low to high half is internal; all 64 bits wrap to 0.
- A write to either half of a counter replaces that half and suppresses the whole counter's increment that cycle. The other half holds.
- No read-during-write forwarding: ex_csr_rdata_o shows pre-write state.

## Timing
- Reset values:
  - mstatus = 32'h0000_1800, mtvec = MTVEC_RESET & ~3.
  - mie, mscratch, mepc, mcause, mtval, mip, counters = 0.
  - All csr_*_o outputs equal these reset values; ex_csr_rdata_o and illegal_csr_o follow the combinational rules.
- Writes: register updated at the rising edge after we is sampled; visible on ex_csr_rdata_o and csr_*_o in the next cycle (1-cycle latency).
- mip: timer_irq_i/sw_irq_i are registered once, so csr_mip_o follows the inputs with a 1-cycle delay. No edge detection; pure level.
- Counters: value read in cycle N+1 equals value in cycle N plus that cycle's increment.
- Reset asserted mid-operation: all state returns to reset values asynchronously; pending writes are lost.

## Test plan
- Reset, then read 0x300, 0x301, 0xF14 with MHARTID=5 -> 32'h0000_1800, 32'h4000_1100, 32'h5; illegal_csr_o=0.
- Execute stage writes 32'hFFFF_FFFF to 0x300, 0x304, 0x305, 0x341 -> reads next cycle return 32'h0000_1888, 32'h0000_0888, 32'hFFFF_FFFC, 32'hFFFF_FFFC.
- Same cycle: execute stage writes 0x342=32'h1 and trap controller writes 0x342=32'h8000_0007 -> mcause=32'h8000_0007. Repeat with the trap controller on 0x341 -> both registers updated.
- Execute stage writes mcycle=32'hFFFF_FFFE, mcycleh=0, with no further writes -> two cycles later mcycleh=1 and mcycle=0. minstret does not change while instr_retire_i=0, and increments by 3 after 3 retire pulses.
- ex_csr_req_i with write to 0xF14 and read of 0x7C0 -> illegal_csr_o=1, rdata=0, mhartid unchanged. Trap-controller write to 0x301 -> ignored.
- Raise timer_irq_i at cycle N -> csr_mip_o[7]=1 from cycle N+1. Drop it at M -> csr_mip_o[7]=0 from M+1. Assert rst_ni=0 mid-count -> mcycle=0 immediately.
